// File: rtl/wb_stage.sv
// Writeback/commit stage: load extraction, register-file write port, trap entry/return
// sequencing with fetch redirect and pipeline flush, and the retired-instruction counter.
module wb_stage #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR    = 32'h0000_2000,
  parameter int                    CAUSE_WIDTH    = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic                      excpt_i,
  input  logic [CAUSE_WIDTH-1:0]    excpt_cause_i,
  input  logic [DATA_WIDTH-1:0]     excpt_tval_i,
  input  logic                      reg_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wr_reg_i,
  input  logic                      is_load_i,
  input  logic [1:0]                access_size_i,
  input  logic                      load_unsigned_i,
  input  logic [1:0]                byte_offset_i,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic                      mret_i,
  output logic                      rf_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_wr_data_o,
  output logic                      flush_o,
  output logic                      redirect_valid_o,
  output logic [DATA_WIDTH-1:0]     redirect_pc_o,
  output logic                      trap_bypass_mmu_o,
  output logic [DATA_WIDTH-1:0]     mepc_o,
  output logic [DATA_WIDTH-1:0]     mcause_o,
  output logic [DATA_WIDTH-1:0]     mtval_o,
  output logic [63:0]               instret_o,
  output logic                      fatal_o
);

  typedef enum logic [2:0] {
    S_RUN,
    S_TRAP,
    S_HANDLER,
    S_RET,
    S_HALT
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mepc_q;
  logic [DATA_WIDTH-1:0] mcause_q;
  logic [DATA_WIDTH-1:0] mtval_q;
  logic [63:0]           instret_q;

  logic                  executing;
  logic                  retire;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  ld_sign;

  // Only RUN and HANDLER accept instructions; TRAP/RET cycles carry flushed work.
  assign executing = (state_q == S_RUN) || (state_q == S_HANDLER);
  assign retire    = executing && valid_i && !excpt_i;

  assign rf_wr_en_o   = retire && reg_wr_en_i && (wr_reg_i != '0);
  assign rf_wr_addr_o = wr_reg_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ld_byte      = mem_data_i[{byte_offset_i, 3'b000} +: 8];
    ld_half      = mem_data_i[{byte_offset_i[1], 4'b0000} +: 16];
    ld_sign      = 1'b0;
    rf_wr_data_o = alu_data_i;
    if (is_load_i) begin
      unique case (access_size_i)
        2'b00: begin
          ld_sign      = !load_unsigned_i && ld_byte[7];
          rf_wr_data_o = {{(DATA_WIDTH-8){ld_sign}}, ld_byte};
        end
        2'b01: begin
          ld_sign      = !load_unsigned_i && ld_half[15];
          rf_wr_data_o = {{(DATA_WIDTH-16){ld_sign}}, ld_half};
        end
        default: rf_wr_data_o = mem_data_i;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q           <= S_RUN;
      mepc_q            <= '0;
      mcause_q          <= '0;
      mtval_q           <= '0;
      flush_o           <= 1'b0;
      redirect_valid_o  <= 1'b0;
      redirect_pc_o     <= '0;
      trap_bypass_mmu_o <= 1'b0;
      fatal_o           <= 1'b0;
    end else begin
      flush_o           <= 1'b0;
      redirect_valid_o  <= 1'b0;
      redirect_pc_o     <= '0;
      trap_bypass_mmu_o <= 1'b0;
      fatal_o           <= 1'b0;
      unique case (state_q)
        S_RUN: begin
          // An exception wins over mret; mret in RUN simply retires as a NOP.
          if (valid_i && excpt_i) begin
            state_q           <= S_TRAP;
            mepc_q            <= pc_i;
            mcause_q          <= {{(DATA_WIDTH-CAUSE_WIDTH){1'b0}}, excpt_cause_i};
            mtval_q           <= excpt_tval_i;
            flush_o           <= 1'b1;
            redirect_valid_o  <= 1'b1;
            redirect_pc_o     <= TRAP_VECTOR;
            trap_bypass_mmu_o <= 1'b1;
          end
        end
        S_TRAP: begin
          state_q           <= S_HANDLER;
          trap_bypass_mmu_o <= 1'b1;
        end
        S_HANDLER: begin
          if (valid_i && excpt_i) begin
            state_q <= S_HALT;
            flush_o <= 1'b1;
            fatal_o <= 1'b1;
          end else if (valid_i && mret_i) begin
            state_q           <= S_RET;
            flush_o           <= 1'b1;
            redirect_valid_o  <= 1'b1;
            redirect_pc_o     <= mepc_q;
            trap_bypass_mmu_o <= 1'b1;
          end else begin
            trap_bypass_mmu_o <= 1'b1;
          end
        end
        S_RET: begin
          state_q <= S_RUN;
        end
        S_HALT: begin
          flush_o <= 1'b1;
          fatal_o <= 1'b1;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign mepc_o    = mepc_q;
  assign mcause_o  = mcause_q;
  assign mtval_o   = mtval_q;
  assign instret_o = instret_q;

endmodule
